// File: rtl/double_read_single_write_pkg.sv
// rtl/double_read_single_write_pkg.sv - shared types and constants for the dual-reader holding register
//
// Contents:
//   DEFAULT_WIDTH   default data word width
//   turn_e          round-robin arbiter state (TURN_1 / TURN_2)
//   next_turn()     arbiter successor given this cycle's grants
package double_read_single_write_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic {
        TURN_1 = 1'b0,
        TURN_2 = 1'b1
    } turn_e;

    // The reader just served yields priority to the other one; with no
    // delivery the arbiter keeps its current preference.
    function automatic turn_e next_turn(input turn_e cur, input logic grant_1,
                                        input logic grant_2);
        turn_e nxt;
        nxt = cur;
        if (grant_1) begin
            nxt = TURN_2;
        end else if (grant_2) begin
            nxt = TURN_1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/double_read_single_write_reader_status.sv
// rtl/double_read_single_write_reader_status.sv - per-reader delivery and freshness/overrun state
//
// Ports:
//   clk           sole clock, rising edge
//   reset_n       asynchronous active-low reset
//   grant         this reader is served on this edge
//   write_enable  producer stores a new word on this edge
//   store_data    current contents of the shared storage register
//   read_data     last word delivered to this reader (registered)
//   read_valid    one-cycle pulse following a delivery
//   fresh         stored word not yet delivered to this reader
//   overrun       sticky: a fresh word was overwritten before being taken
module reader_status
    import double_read_single_write_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             grant,
    input  logic             write_enable,
    input  logic [width-1:0] store_data,
    output logic [width-1:0] read_data,
    output logic             read_valid,
    output logic             fresh,
    output logic             overrun
);

    logic [width-1:0] read_data_q, read_data_d;
    logic             read_valid_q, read_valid_d;
    logic             fresh_q, fresh_d;
    logic             overrun_q, overrun_d;

    // The top never grants while a write is in progress, so the write and
    // grant branches below are mutually exclusive in practice; write is
    // still checked first so this block is self-consistent on its own.
    always_comb begin
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        fresh_d      = fresh_q;
        overrun_d    = overrun_q;

        if (write_enable) begin
            fresh_d   = 1'b1;
            // Overwriting a word this reader never took is an overrun;
            // the flag stays set until the reader is next served.
            overrun_d = overrun_q | fresh_q;
        end else if (grant) begin
            read_data_d  = store_data;
            read_valid_d = 1'b1;
            fresh_d      = 1'b0;
            overrun_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            fresh_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            fresh_q      <= fresh_d;
            overrun_q    <= overrun_d;
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign fresh      = fresh_q;
    assign overrun    = overrun_q;

endmodule

// File: rtl/double_read_single_write.sv
// rtl/double_read_single_write.sv - single-writer, dual-reader holding register with round-robin read arbiter
//
// Ports:
//   clk                            sole clock, rising edge
//   reset_n                        asynchronous active-low reset
//   write_data / write_enable      producer word and store strobe
//   read_enable_1 / read_enable_2  level read requests
//   read_data_1 / read_data_2      last word delivered to each reader
//   read_valid_1 / read_valid_2    delivery pulse, one cycle after grant
//   fresh_1 / fresh_2              stored word not yet seen by that reader
//   overrun_1 / overrun_2          sticky missed-word flag per reader
module double_read_single_write
    import double_read_single_write_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [width-1:0] write_data,
    input  logic             write_enable,
    input  logic             read_enable_1,
    input  logic             read_enable_2,
    output logic [width-1:0] read_data_1,
    output logic [width-1:0] read_data_2,
    output logic             read_valid_1,
    output logic             read_valid_2,
    output logic             fresh_1,
    output logic             fresh_2,
    output logic             overrun_1,
    output logic             overrun_2
);

    logic [width-1:0] store_q, store_d;
    turn_e            turn_q, turn_d;
    logic             grant_1, grant_2;

    // Writes take the single internal path; requests are levels, so a
    // blocked reader is simply served on a later cycle.
    always_comb begin
        grant_1 = 1'b0;
        grant_2 = 1'b0;
        if (!write_enable) begin
            grant_1 = read_enable_1 && (!read_enable_2 || (turn_q == TURN_1));
            grant_2 = read_enable_2 && (!read_enable_1 || (turn_q == TURN_2));
        end
    end

    always_comb begin
        store_d = store_q;
        if (write_enable) begin
            store_d = write_data;
        end
        turn_d = next_turn(turn_q, grant_1, grant_2);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            store_q <= '0;
            turn_q  <= TURN_1;
        end else begin
            store_q <= store_d;
            turn_q  <= turn_d;
        end
    end

    reader_status #(.width(width)) u_reader_1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .grant        (grant_1),
        .write_enable (write_enable),
        .store_data   (store_q),
        .read_data    (read_data_1),
        .read_valid   (read_valid_1),
        .fresh        (fresh_1),
        .overrun      (overrun_1)
    );

    reader_status #(.width(width)) u_reader_2 (
        .clk          (clk),
        .reset_n      (reset_n),
        .grant        (grant_2),
        .write_enable (write_enable),
        .store_data   (store_q),
        .read_data    (read_data_2),
        .read_valid   (read_valid_2),
        .fresh        (fresh_2),
        .overrun      (overrun_2)
    );

endmodule

// File: tb/tb_double_read_single_write.sv
// tb/tb_double_read_single_write.sv - directed table-driven bench for double_read_single_write
module tb_double_read_single_write;

    logic        clk;
    logic        reset_n;
    logic [15:0] write_data;
    logic        write_enable;
    logic        read_enable_1;
    logic        read_enable_2;
    logic [15:0] read_data_1;
    logic [15:0] read_data_2;
    logic        read_valid_1;
    logic        read_valid_2;
    logic        fresh_1;
    logic        fresh_2;
    logic        overrun_1;
    logic        overrun_2;

    int checks;
    int errors;

    double_read_single_write #(.width(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .write_data    (write_data),
        .write_enable  (write_enable),
        .read_enable_1 (read_enable_1),
        .read_enable_2 (read_enable_2),
        .read_data_1   (read_data_1),
        .read_data_2   (read_data_2),
        .read_valid_1  (read_valid_1),
        .read_valid_2  (read_valid_2),
        .fresh_1       (fresh_1),
        .fresh_2       (fresh_2),
        .overrun_1     (overrun_1),
        .overrun_2     (overrun_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Observed state: {rd1, rd2, rv1, rv2, f1, f2, o1, o2, turn}
    typedef struct {
        logic        we;
        logic [15:0] wd;
        logic        re1;
        logic        re2;
        logic [38:0] exp;
    } vec_t;

    vec_t vecs[18];

    function automatic logic [38:0] pk(input logic [15:0] rd1, input logic [15:0] rd2,
                                       input logic rv1, input logic rv2,
                                       input logic f1, input logic f2,
                                       input logic o1, input logic o2,
                                       input logic turn);
        return {rd1, rd2, rv1, rv2, f1, f2, o1, o2, turn};
    endfunction

    function automatic logic [38:0] observed();
        logic t;
        t = dut.turn_q;
        return {read_data_1, read_data_2, read_valid_1, read_valid_2,
                fresh_1, fresh_2, overrun_1, overrun_2, t};
    endfunction

    task automatic check(input string name, input logic [38:0] act, input logic [38:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got rd1=%h rd2=%h rv=%b%b fr=%b%b ov=%b%b turn=%b, want rd1=%h rd2=%h rv=%b%b fr=%b%b ov=%b%b turn=%b",
                     name, act[38:23], act[22:7], act[6], act[5], act[4], act[3], act[2], act[1], act[0],
                     exp[38:23], exp[22:7], exp[6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [15:0] wd, input logic re1, input logic re2);
        write_enable  = we;
        write_data    = wd;
        read_enable_1 = re1;
        read_enable_2 = re2;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //               we   wd        re1   re2   rd1       rd2       rv1   rv2   f1    f2    o1    o2    turn
        vecs[0]  = '{1'b1, 16'h1234, 1'b1, 1'b1, pk(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)};
        vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, pk(16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1)};
        vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, pk(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        vecs[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, pk(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        vecs[4]  = '{1'b1, 16'hA5A5, 1'b0, 1'b0, pk(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)};
        vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, pk(16'hA5A5, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1)};
        vecs[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, pk(16'hA5A5, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1)};
        vecs[7]  = '{1'b1, 16'h0001, 1'b0, 1'b0, pk(16'hA5A5, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1)};
        vecs[8]  = '{1'b1, 16'h0002, 1'b0, 1'b0, pk(16'hA5A5, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1)};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, pk(16'hA5A5, 16'h0002, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)};
        vecs[10] = '{1'b1, 16'hBEEF, 1'b0, 1'b1, pk(16'hA5A5, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, pk(16'hA5A5, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, pk(16'hA5A5, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)};
        vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, pk(16'hBEEF, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
        vecs[14] = '{1'b1, 16'h00FF, 1'b0, 1'b0, pk(16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1)};
        vecs[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, pk(16'h00FF, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1)};
        vecs[16] = '{1'b0, 16'h0000, 1'b1, 1'b0, pk(16'h00FF, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1)};
        vecs[17] = '{1'b0, 16'h0000, 1'b0, 1'b0, pk(16'h00FF, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1)};

        reset_n = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        step();
        step();
        check("reset_state", observed(), '0);
        reset_n = 1'b1;
        step();
        check("idle_after_reset", observed(), '0);

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].we, vecs[i].wd, vecs[i].re1, vecs[i].re2);
            step();
            check($sformatf("vec%0d", i), observed(), vecs[i].exp);
        end

        // Asynchronous reset mid-cycle while both readers hold requests.
        drive(1'b0, 16'h0000, 1'b1, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_immediate", observed(), '0);
        step();
        check("reset_held_over_edge", observed(), '0);

        // Release mid-cycle; held requests are served from the cleared register.
        reset_n = 1'b1;
        step();
        check("post_reset_grant_1", observed(),
              pk(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        step();
        check("post_reset_grant_2", observed(),
              pk(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Write with both requests pending: write only, then both served in arbiter order.
        drive(1'b1, 16'h5A5A, 1'b1, 1'b1);
        step();
        check("wr_both_pending", observed(),
              pk(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        drive(1'b0, 16'h0000, 1'b1, 1'b1);
        step();
        check("wr_both_first", observed(),
              pk(16'h5A5A, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        step();
        check("wr_both_second", observed(),
              pk(16'h5A5A, 16'h5A5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        step();
        check("final_idle", observed(),
              pk(16'h5A5A, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/double_read_single_write.md
# double_read_single_write

Single-writer, dual-reader holding register: the counterpart of the two-source alternating writer. One producer writes a `width`-bit word; two independent consumers each request it over their own read port. A two-state round-robin arbiter serialises the internal single read path, and per-reader freshness/overrun tracking tells each consumer whether it has missed or already seen the current word. It sits between one producer stage and two consumer stages in the lab datapath.

## Interface
- `width`, 16, data word width in bits
- `clk`  input  1  sole clock, rising edge
- `reset_n`  input  1  asynchronous, active-low reset
- `write_data`  input  width  word to store
- `write_enable`  input  1  store `write_data` this edge
- `read_enable_1`, `read_enable_2`  input  1 each  level read request, reader 1 / reader 2
- `read_data_1`, `read_data_2`  output  width each  last word delivered to that reader (registered)
- `read_valid_1`, `read_valid_2`  output  1 each  one-cycle pulse: delivery made this cycle
- `fresh_1`, `fresh_2`  output  1 each  stored word not yet delivered to that reader
- `overrun_1`, `overrun_2`  output  1 each  sticky: a fresh word was overwritten before that reader took it

## Operation
- Reset (`reset_n`=0, asynchronous): storage register=0, `read_data_*`=0, `read_valid_*`=0, `fresh_*`=0, `overrun_*`=0, arbiter state `TURN_1`.
- Write (`write_enable`=1): register <= `write_data`; `fresh_1`, `fresh_2` <= 1; for each reader with fresh=1 before the write, overrun <= 1.
- Write has priority: while `write_enable`=1 no read is served, `read_valid_*`=0; requests stay pending (level).
- Read (`write_enable`=0): at most one reader served per cycle.
  - Only reader k requesting: serve k.
  - Both requesting: serve reader named by arbiter state.
  - Served reader k: `read_data_k` <= register, `read_valid_k`=1 next cycle, `fresh_k` <= 0, `overrun_k` <= 0.
  - Unserved requester: nothing changes; served on a later cycle if request held.
- Arbiter states: `TURN_1`, `TURN_2`. After any delivery to reader 1 -> `TURN_2`; after delivery to reader 2 -> `TURN_1`; no delivery -> hold.
- Reading a non-fresh word is legal: stale value re-delivered, `read_valid_k` pulses, `fresh_k` stays 0.
- `read_data_k` holds its value between deliveries; never X.

## Timing
- Write at edge N: register updated at N; a read granted at N+1 delivers the new word, `read_valid` high after N+1.
- Request-to-data latency: 1 cycle if granted; worst case 2 cycles under continuous contention with no writes.
- `read_valid_k` is a registered single-cycle pulse per grant; a held request with no contention pulses every cycle.
- Write and both read requests in the same cycle: write only; both reads next cycle (arbiter order), both see the new word.
- Overrun set and clear on the same edge impossible (write blocks reads).
- `reset_n` deassertion mid-traffic: first active edge behaves as from reset state; requests held across reset are served from register=0.

## Structure
- Shared package: arbiter state type (`TURN_1`, `TURN_2`), `DEFAULT_WIDTH`=16.
- One sub-module, `reader_status`, instantiated twice: holds `read_data`, `read_valid`, `fresh`, `overrun` for one reader, driven by `grant`, `write_enable`, and the register value. Top holds storage register and arbiter.

## Test plan
- Reset: drive `reset_n`=0 asynchronously mid-cycle -> all outputs 0 immediately, arbiter `TURN_1`.
- Single reader: write 16'hA5A5, then `read_enable_1`=1 one cycle -> next cycle `read_data_1`=16'hA5A5, `read_valid_1`=1, `fresh_1`=0, `fresh_2`=1.
- Contention: write 16'h1234, both requests held 2 cycles -> reader 1 served first cycle, reader 2 second; both `read_data`=16'h1234; arbiter ends `TURN_1`.
- Overrun: write 16'h0001, write 16'h0002 with no reads -> `overrun_1`=`overrun_2`=1; reader 2 reads -> `read_data_2`=16'h0002, `overrun_2`=0, `overrun_1` stays 1.
- Write priority: `write_enable`=1 with 16'hBEEF plus `read_enable_2`=1 -> no `read_valid_2` that cycle; next cycle `read_data_2`=16'hBEEF.
- Stale re-read: after reader 1 consumes 16'h00FF, read again -> `read_valid_1`=1, `read_data_1`=16'h00FF, `fresh_1`=0.
